// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H transmit path: FSM states, byte width
// and the pointer-width helper.
package ft2232h_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ft2232h_byte_ram.sv
// DEPTH x 8 byte storage: synchronous write, asynchronous read.
module ft2232h_byte_ram
    import ft2232h_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ft2232h_tx_burst_buffer.sv
// Burst staging buffer ahead of the FT2232H sync-FIFO TX stage. Bytes are
// held until a fill threshold, flush or idle timeout releases them.
module ft2232h_tx_burst_buffer
    import ft2232h_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned BURST   = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  flush,
    output logic [BYTE_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_pop,
    output logic [clog2(DEPTH):0] level
);

    localparam int unsigned AW   = clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned TW_R = clog2(TIMEOUT + 1);
    localparam int unsigned TW   = (TW_R < 1) ? 1 : TW_R;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);
    localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT);

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              wr, rd;
    logic [BYTE_W-1:0] rdata;

    ft2232h_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Handshakes derive from registered count only, so a same-cycle pop
    // never opens s_ready on a full buffer.
    always_comb begin
        s_ready  = !rst && (count_q != DEPTH_C);
        m_valid  = (state_q == DRAIN) && (count_q != '0);
        wr       = s_valid && s_ready;
        rd       = m_valid && m_pop;
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        count_d  = count_q + CW'(wr) - CW'(rd);
        m_data   = m_valid ? rdata : '0;
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        unique case (state_q)
            IDLE: begin
                if (wr) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                timer_d = (timer_q == TMAX_C) ? TMAX_C : timer_q + TW'(1);
                if ((count_d >= BURST_C) || flush || (timer_q == TMAX_C)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
        end
    end

    assign level = count_q;

endmodule

// File: tb/tb_ft2232h_tx_burst_buffer.sv
// Self-checking bench: three buffer instances with different geometries,
// checked against queue-based expectations.
module tb_ft2232h_tx_burst_buffer;
    import ft2232h_pkg::*;

    localparam int unsigned B_TIMEOUT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default geometry (DEPTH 512, BURST 64, TIMEOUT 255)
    logic       a_rst = 1'b1, a_svalid = 1'b0, a_flush = 1'b0, a_mpop = 1'b0;
    logic [7:0] a_sdata = '0, a_mdata;
    logic       a_sready, a_mvalid;
    logic [9:0] a_level;
    // Instance B: short timeout
    logic       b_rst = 1'b1, b_svalid = 1'b0, b_flush = 1'b0, b_mpop = 1'b0;
    logic [7:0] b_sdata = '0, b_mdata;
    logic       b_sready, b_mvalid;
    logic [4:0] b_level;
    // Instance C: tiny buffer for full/wrap behaviour
    logic       c_rst = 1'b1, c_svalid = 1'b0, c_flush = 1'b0, c_mpop = 1'b0;
    logic [7:0] c_sdata = '0, c_mdata;
    logic       c_sready, c_mvalid;
    logic [3:0] c_level;

    ft2232h_tx_burst_buffer #(.DEPTH(512), .BURST(64), .TIMEOUT(255)) u_a (
        .clk(clk), .rst(a_rst), .s_data(a_sdata), .s_valid(a_svalid), .s_ready(a_sready),
        .flush(a_flush), .m_data(a_mdata), .m_valid(a_mvalid), .m_pop(a_mpop), .level(a_level));
    ft2232h_tx_burst_buffer #(.DEPTH(16), .BURST(8), .TIMEOUT(B_TIMEOUT)) u_b (
        .clk(clk), .rst(b_rst), .s_data(b_sdata), .s_valid(b_svalid), .s_ready(b_sready),
        .flush(b_flush), .m_data(b_mdata), .m_valid(b_mvalid), .m_pop(b_mpop), .level(b_level));
    ft2232h_tx_burst_buffer #(.DEPTH(8), .BURST(8), .TIMEOUT(255)) u_c (
        .clk(clk), .rst(c_rst), .s_data(c_sdata), .s_valid(c_svalid), .s_ready(c_sready),
        .flush(c_flush), .m_data(c_mdata), .m_valid(c_mvalid), .m_pop(c_mpop), .level(c_level));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        tick(); tick();
        checks++;
        if (a_mvalid !== 1'b0 || a_level !== 10'd0 || a_sready !== 1'b0 || a_mdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_a: m_valid=%b level=%0d s_ready=%b m_data=%h want 0 0 0 00",
                     a_mvalid, a_level, a_sready, a_mdata);
        end
        checks++;
        if (b_mvalid !== 1'b0 || b_level !== 5'd0 || b_sready !== 1'b0 ||
            c_mvalid !== 1'b0 || c_level !== 4'd0 || c_sready !== 1'b0) begin
            errors++;
            $display("FAIL reset_bc: b m_valid=%b level=%0d s_ready=%b c m_valid=%b level=%0d s_ready=%b want all 0",
                     b_mvalid, b_level, b_sready, c_mvalid, c_level, c_sready);
        end
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        #1;
        checks++;
        if (a_sready !== 1'b1 || b_sready !== 1'b1 || c_sready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got a=%b b=%b c=%b want 1 1 1", a_sready, b_sready, c_sready);
        end
        tick();
    endtask

    task automatic test_threshold();
        a_svalid = 1'b1;
        for (int i = 0; i < 63; i++) begin
            a_sdata = 8'(i);
            tick();
            checks++;
            if (a_mvalid !== 1'b0 || a_level !== 10'(i + 1)) begin
                errors++;
                $display("FAIL threshold_hold: byte %0d m_valid=%b level=%0d want 0 %0d", i, a_mvalid, a_level, i + 1);
            end
        end
        a_sdata = 8'h3F;
        tick();
        a_svalid = 1'b0;
        checks++;
        if (a_mvalid !== 1'b1 || a_level !== 10'd64 || u_a.state_q !== DRAIN) begin
            errors++;
            $display("FAIL threshold_release: m_valid=%b level=%0d state=%0d want 1 64 DRAIN",
                     a_mvalid, a_level, u_a.state_q);
        end
        a_mpop = 1'b1;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (a_mvalid !== 1'b1 || a_mdata !== 8'(i)) begin
                errors++;
                $display("FAIL threshold_data: idx %0d m_valid=%b m_data=%h want 1 %h", i, a_mvalid, a_mdata, 8'(i));
            end
            tick();
        end
        a_mpop = 1'b0;
        checks++;
        if (a_mvalid !== 1'b0 || a_level !== 10'd0 || u_a.state_q !== IDLE) begin
            errors++;
            $display("FAIL threshold_empty: m_valid=%b level=%0d state=%0d want 0 0 IDLE",
                     a_mvalid, a_level, u_a.state_q);
        end
    endtask

    task automatic test_flush();
        logic [7:0] q[$];
        logic [7:0] d;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        checks++;
        if (a_mvalid !== 1'b0 || u_a.state_q !== IDLE) begin
            errors++;
            $display("FAIL flush_idle_ignored: m_valid=%b state=%0d want 0 IDLE", a_mvalid, u_a.state_q);
        end
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            a_sdata = d; a_svalid = 1'b1;
            q.push_back(d);
            tick();
        end
        a_svalid = 1'b0;
        checks++;
        if (a_mvalid !== 1'b0 || a_level !== 10'd5) begin
            errors++;
            $display("FAIL flush_pre: m_valid=%b level=%0d want 0 5", a_mvalid, a_level);
        end
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        checks++;
        if (a_mvalid !== 1'b1 || a_level !== 10'd5) begin
            errors++;
            $display("FAIL flush_release: m_valid=%b level=%0d want 1 5", a_mvalid, a_level);
        end
        a_mpop = 1'b1;
        while (q.size() > 0) begin
            checks++;
            if (a_mvalid !== 1'b1 || a_mdata !== q[0]) begin
                errors++;
                $display("FAIL flush_data: m_valid=%b m_data=%h want 1 %h", a_mvalid, a_mdata, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        a_mpop = 1'b0;
        checks++;
        if (a_mvalid !== 1'b0 || a_level !== 10'd0 || u_a.state_q !== IDLE) begin
            errors++;
            $display("FAIL flush_done: m_valid=%b level=%0d state=%0d want 0 0 IDLE", a_mvalid, a_level, u_a.state_q);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] d;
        a_svalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_sdata = 8'($urandom);
            tick();
        end
        a_svalid = 1'b0;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        checks++;
        if (a_mvalid !== 1'b1 || a_level !== 10'd20) begin
            errors++;
            $display("FAIL rstmid_setup: m_valid=%b level=%0d want 1 20", a_mvalid, a_level);
        end
        a_rst = 1'b1; a_svalid = 1'b1; a_mpop = 1'b1;
        tick();
        checks++;
        if (a_mvalid !== 1'b0 || a_level !== 10'd0 || a_sready !== 1'b0 || a_mdata !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_cleared: m_valid=%b level=%0d s_ready=%b m_data=%h want 0 0 0 00",
                     a_mvalid, a_level, a_sready, a_mdata);
        end
        a_rst = 1'b0; a_svalid = 1'b0; a_mpop = 1'b0;
        tick();
        checks++;
        if (a_sready !== 1'b1 || u_a.state_q !== IDLE || a_level !== 10'd0) begin
            errors++;
            $display("FAIL rstmid_after: s_ready=%b state=%0d level=%0d want 1 IDLE 0", a_sready, u_a.state_q, a_level);
        end
        d = 8'($urandom);
        a_sdata = d; a_svalid = 1'b1;
        tick();
        a_svalid = 1'b0; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        checks++;
        if (a_mvalid !== 1'b1 || a_mdata !== d || a_level !== 10'd1) begin
            errors++;
            $display("FAIL rstmid_fresh: m_valid=%b m_data=%h level=%0d want 1 %h 1", a_mvalid, a_mdata, a_level, d);
        end
        a_mpop = 1'b1;
        tick();
        a_mpop = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] q[$];
        logic [7:0] d;
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            b_sdata = d; b_svalid = 1'b1;
            q.push_back(d);
            tick();
            n++;
        end
        b_svalid = 1'b0;
        while (b_mvalid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != int'(B_TIMEOUT) + 2) begin
            errors++;
            $display("FAIL timeout_latency: m_valid after %0d cycles want %0d", n, B_TIMEOUT + 2);
        end
        b_mpop = 1'b1;
        while (q.size() > 0) begin
            checks++;
            if (b_mvalid !== 1'b1 || b_mdata !== q[0]) begin
                errors++;
                $display("FAIL timeout_data: m_valid=%b m_data=%h want 1 %h", b_mvalid, b_mdata, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        b_mpop = 1'b0;
        checks++;
        if (b_mvalid !== 1'b0 || b_level !== 5'd0) begin
            errors++;
            $display("FAIL timeout_done: m_valid=%b level=%0d want 0 0", b_mvalid, b_level);
        end
    endtask

    task automatic test_full_stall();
        logic [7:0] data[10];
        logic [7:0] q[$];
        int idx = 0;
        foreach (data[i]) data[i] = 8'($urandom);
        c_svalid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            c_sdata = data[idx];
            if (c_sready === 1'b1 && idx < 10) begin
                q.push_back(data[idx]);
                idx++;
            end
            tick();
        end
        checks++;
        if (idx != 8 || c_level !== 4'd8 || c_sready !== 1'b0 || c_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: accepted=%0d level=%0d s_ready=%b m_valid=%b want 8 8 0 1",
                     idx, c_level, c_sready, c_mvalid);
        end
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (c_mdata !== q[0] || c_mvalid !== 1'b1 || c_sready !== 1'b0 || c_level !== 4'd8) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d m_data=%h m_valid=%b s_ready=%b level=%0d want %h 1 0 8",
                         k, c_mdata, c_mvalid, c_sready, c_level, q[0]);
            end
            tick();
        end
        c_mpop = 1'b1;
        tick();
        c_mpop = 1'b0;
        void'(q.pop_front());
        checks++;
        if (c_sready !== 1'b1 || c_level !== 4'd7) begin
            errors++;
            $display("FAIL full_pop_ready: s_ready=%b level=%0d want 1 7", c_sready, c_level);
        end
        tick();
        q.push_back(data[8]);
        c_svalid = 1'b0;
        checks++;
        if (c_level !== 4'd8 || c_sready !== 1'b0) begin
            errors++;
            $display("FAIL full_refill: level=%0d s_ready=%b want 8 0", c_level, c_sready);
        end
        c_mpop = 1'b1;
        while (q.size() > 0) begin
            checks++;
            if (c_mvalid !== 1'b1 || c_mdata !== q[0]) begin
                errors++;
                $display("FAIL full_drain: m_valid=%b m_data=%h want 1 %h", c_mvalid, c_mdata, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        c_mpop = 1'b0;
        checks++;
        if (c_mvalid !== 1'b0 || c_level !== 4'd0 || u_c.state_q !== IDLE) begin
            errors++;
            $display("FAIL full_done: m_valid=%b level=%0d state=%0d want 0 0 IDLE", c_mvalid, c_level, u_c.state_q);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [7:0] q[$];
        logic [7:0] d;
        c_svalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            c_sdata = d;
            q.push_back(d);
            tick();
        end
        c_svalid = 1'b0; c_flush = 1'b1;
        tick();
        c_flush = 1'b0;
        c_svalid = 1'b1; c_mpop = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            c_sdata = d;
            checks++;
            if (c_mvalid !== 1'b1 || c_mdata !== q[0] || c_level !== 4'd4) begin
                errors++;
                $display("FAIL wrap_stream: cycle %0d m_valid=%b m_data=%h level=%0d want 1 %h 4",
                         i, c_mvalid, c_mdata, c_level, q[0]);
            end
            tick();
            void'(q.pop_front());
            q.push_back(d);
        end
        c_svalid = 1'b0;
        while (q.size() > 0) begin
            checks++;
            if (c_mvalid !== 1'b1 || c_mdata !== q[0]) begin
                errors++;
                $display("FAIL wrap_drain: m_valid=%b m_data=%h want 1 %h", c_mvalid, c_mdata, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        c_mpop = 1'b0;
        checks++;
        if (c_level !== 4'd0 || c_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: level=%0d m_valid=%b want 0 0", c_level, c_mvalid);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] d;
        logic       sv, pp, wr, rd;
        int n = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            checks++;
            if (c_level !== 4'(q.size()) || c_sready !== (q.size() != 8)) begin
                errors++;
                $display("FAIL rand_level: cycle %0d level=%0d s_ready=%b want %0d %b",
                         cyc, c_level, c_sready, q.size(), q.size() != 8);
            end
            checks++;
            if (c_mvalid === 1'b1) begin
                if (q.size() == 0 || c_mdata !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data: cycle %0d m_data=%h stored=%0d want head %h",
                             cyc, c_mdata, q.size(), (q.size() > 0) ? q[0] : 8'h00);
                end
            end else if (c_mdata !== 8'd0) begin
                errors++;
                $display("FAIL rand_idle_data: cycle %0d m_data=%h want 00", cyc, c_mdata);
            end
            sv = ($urandom_range(0, 99) < 60);
            pp = ($urandom_range(0, 99) < 50);
            d  = 8'($urandom);
            c_svalid = sv; c_mpop = pp; c_sdata = d;
            c_flush  = ($urandom_range(0, 99) < 3);
            wr = sv && (q.size() != 8);
            rd = (c_mvalid === 1'b1) && pp && (q.size() > 0);
            tick();
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
        c_svalid = 1'b0; c_flush = 1'b1;
        tick();
        c_flush = 1'b0; c_mpop = 1'b1;
        while (q.size() > 0 && n < 400) begin
            if (c_mvalid === 1'b1) begin
                checks++;
                if (c_mdata !== q[0]) begin
                    errors++;
                    $display("FAIL rand_drain: m_data=%h want %h", c_mdata, q[0]);
                end
                void'(q.pop_front());
            end
            tick();
            n++;
        end
        c_mpop = 1'b0;
        checks++;
        if (q.size() != 0 || c_level !== 4'd0) begin
            errors++;
            $display("FAIL rand_final: left=%0d level=%0d want 0 0", q.size(), c_level);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_threshold();
        test_flush();
        test_reset_mid_burst();
        test_timeout();
        test_full_stall();
        test_back_to_back_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft2232h_tx_burst_buffer.md
# ft2232h_tx_burst_buffer

Byte staging buffer directly upstream of the FT2232H synchronous-FIFO transmit stage. It accepts bytes from user logic over a valid/ready port and stores them in a DEPTH-byte circular buffer. It presents them to the TX stage only in bursts, so the USB host sees full packets rather than trickled single bytes. A burst is released by a fill threshold, an explicit flush, or an idle timeout.

## Interface
Parameters:
- DEPTH, 512: storage size in bytes; power of two, ≥ 4.
- BURST, 64: fill level that releases a burst; 1 ≤ BURST ≤ DEPTH.
- TIMEOUT, 255: cycles in ACCUM with no release before a forced release; ≥ 1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  single system clock (FT2232H CLKOUT domain).
  - rst  in  1  synchronous, active-high reset.
- User write port:
  - s_data  in  8  write byte.
  - s_valid  in  1  write request.
  - s_ready  out  1  buffer can accept; write occurs when s_valid && s_ready.
- Control:
  - flush  in  1  request immediate release of all buffered bytes.
- TX-stage port:
  - m_data  out  8  head byte; 0 when m_valid low.
  - m_valid  out  1  head byte is offered to the TX stage.
  - m_pop  in  1  TX stage consumed the head byte this cycle; ignored when m_valid low.
- Status:
  - level  out  log2(DEPTH)+1  bytes currently stored.

## Operation
- Pointers and count:
  - wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH naturally.
  - count is log2(DEPTH)+1 bits; level equals count.
- Handshake signals:
  - s_ready = !rst && (count != DEPTH).
  - The output comes from registered count only; a same-cycle pop never makes s_ready high.
  - m_valid = (state == DRAIN) && (count != 0).
  - m_data = mem[rd_ptr] when m_valid, else 0.
- Per-cycle update:
  - wr = s_valid && s_ready.
  - rd = m_valid && m_pop.
  - count += wr - rd. A simultaneous write and pop leaves count unchanged.
- FSM states (encoded in the package):
  - IDLE: count == 0.
    - A write moves to ACCUM.
    - flush is ignored.
  - ACCUM: timer counts up from 0, saturating at TIMEOUT.
    - Go to DRAIN when next count ≥ BURST, or flush is high, or timer == TIMEOUT.
    - The timer clears on entry to ACCUM.
  - DRAIN: bytes are offered to the TX stage.
    - Go to IDLE when the next count == 0.
    - Writes during DRAIN are accepted and drained in the same burst.
- A TX-stage stall (m_pop low, e.g. txe high) holds m_data and m_valid stable; no byte is lost or repeated.

## Timing
- Reset values: state IDLE, count 0, pointers 0, timer 0, s_ready 0 during rst, m_valid 0, m_data 0, level 0.
- A write in cycle N is reflected in level at N+1.
- Release latency:
  - The write that brings count to BURST is at cycle N.
  - State is DRAIN and m_valid is high at N+1.
- Flush latency: flush at N in ACCUM gives m_valid at N+1.
- Timeout latency: the first write at N enters ACCUM at N+1; m_valid is high at N+TIMEOUT+2.
- Pop of the last byte with no simultaneous write: m_valid is low the next cycle and state is IDLE.
- Full buffer: s_ready low. A pop at N gives s_ready high at N+1.
- Reset mid-burst: all contents are discarded and the reset values apply the next cycle.

## Structure
- Shared package ft2232h_pkg holds:
  - the state enum (IDLE, ACCUM, DRAIN);
  - the BYTE_W = 8 constant;
  - the clog2 helper for pointer widths.
- One sub-module, ft2232h_byte_ram: DEPTH×8 storage with a synchronous write and an asynchronous read at rd_ptr.
- Pointer, count, timer and FSM logic stay in the top module.

## Test plan
- Threshold release: BURST=64. Write 63 bytes 0x00..0x3E.
  - m_valid stays low.
  - Writing the 64th byte raises m_valid the next cycle.
  - m_pop held high yields 0x00..0x3F in order, then m_valid falls and level = 0.
- Timeout release: TIMEOUT=10. Write 3 bytes, then idle.
  - m_valid rises exactly TIMEOUT+2 cycles after the first write.
  - The 3 bytes come out in order.
- Flush: write 5 bytes, pulse flush one cycle.
  - m_valid is high on the next cycle.
  - The 5 bytes drain and the FSM returns to IDLE.
- Full and stall: DEPTH=8, BURST=8. Write 10 bytes with s_valid held high.
  - s_ready falls after 8 bytes; level = 8.
  - m_pop is low for 20 cycles and m_data stays at byte 0.
  - A single pop lets byte 8 in the following cycle.
- Simultaneous write/pop and wrap:
  - In DRAIN, write and pop every cycle for 3×DEPTH cycles.
  - level stays constant and the output sequence matches the input sequence across pointer wrap.
- Reset mid-burst: assert rst during DRAIN with level = 20.
  - Next cycle: m_valid 0, level 0, s_ready 0.
  - After rst deasserts: s_ready 1 and state IDLE.
